// File: rtl/ccff_bitstream_loader.sv
// Byte-stream to configuration-chain serialiser for the logic tiles (ccff_head / ccff_shift_en).
// Optional read-back verify pass from ccff_tail: define CCFF_BITSTREAM_LOADER_VERIFY_EN.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       prog_clk,
  input  logic       pReset,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_LOAD   | shifting CHAIN_LEN bits into the chain
  // S_VERIFY | shifting the resent stream, comparing against ccff_tail
  // S_DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_LEN  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t           r_state;
  logic [7:0]       r_buf;
  logic [3:0]       r_nb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_head;
  logic             r_shift_en;
  logic             r_done;
  logic             w_active;
  logic             w_accept;
  logic             w_pass_end;
  logic [3:0]       w_nb_load;

`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
  logic r_err;
  assign error = r_err;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
  assign error         = 1'b0;
`endif

  // r_nb counts bits still to present after the one currently on ccff_head,
  // so the buffer is only free once the last shift cycle has also ended.
  assign w_active   = (r_state == S_LOAD) || (r_state == S_VERIFY);
  assign s_ready    = w_active && (r_nb == 4'd0) && !r_shift_en && (r_cnt < LP_LEN);
  assign w_accept   = s_valid && s_ready;
  assign w_pass_end = r_shift_en && (r_cnt == LP_LAST);

  always_comb begin
    w_nb_load = 4'd8;
    if (CHAIN_LEN - int'(r_cnt) < 8) w_nb_load = 4'(CHAIN_LEN - int'(r_cnt));
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_nb       <= '0;
      r_cnt      <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_shift_en <= 1'b0;
          if (start) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_nb    <= '0;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
            r_err   <= 1'b0;
`endif
          end
        end
        S_LOAD, S_VERIFY: begin
          if (r_shift_en) r_cnt <= r_cnt + CNT_W'(1);
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
          if (r_state == S_VERIFY && r_shift_en && (ccff_tail != r_head)) r_err <= 1'b1;
`endif
          if (w_pass_end) begin
            r_cnt <= '0;
            if (r_state == S_VERIFY) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
              r_state <= S_VERIFY;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
`endif
            end
          end
          if (r_nb != 4'd0) begin
            r_head     <= r_buf[7];
            r_buf      <= {r_buf[6:0], 1'b0};
            r_nb       <= r_nb - 4'd1;
            r_shift_en <= 1'b1;
          end else if (w_accept) begin
            r_head     <= s_data[7];
            r_buf      <= {s_data[6:0], 1'b0};
            r_nb       <= w_nb_load - 4'd1;
            r_shift_en <= 1'b1;
          end else begin
            r_shift_en <= 1'b0;
          end
        end
        S_DONE: begin
          r_shift_en <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 12-flop chain instance plus a 1-flop chain instance.
// Expected waveforms come from a per-byte cycle model of the stream rules.
module tb_ccff_bitstream_loader;
  localparam int L   = 12;
  localparam int NBY = (L + 7) / 8;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic clk = 1'b0;
  logic pReset = 1'b0;

  logic       start12 = 1'b0, s_valid12 = 1'b0;
  logic [7:0] s_data12 = 8'h00;
  logic       ready12, head12, shift12, tail12, busy12, done12, error12;
  logic [L-1:0] chain12 = '0;

  logic       start1 = 1'b0, s_valid1 = 1'b0;
  logic [7:0] s_data1 = 8'h00;
  logic       ready1, head1, shift1, busy1, done1, error1;
  logic       chain1 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] st_bytes[4];
  int         st_gaps[4];
  logic exp_en[80], exp_head[80], exp_rdy[80], exp_busy[80], exp_done[80], exp_err[80];
  int   m_done;
  logic [L-1:0] m_bits;
  logic m_head = 1'b0, m_err = 1'b0, m_head_n, m_err_n;
  int   last_done, last_nshift;
  logic [L-1:0] last_bits;

  ccff_bitstream_loader #(.CHAIN_LEN(L)) dut12 (
    .prog_clk(clk), .pReset(pReset), .start(start12), .s_data(s_data12), .s_valid(s_valid12),
    .s_ready(ready12), .ccff_head(head12), .ccff_shift_en(shift12), .ccff_tail(tail12),
    .busy(busy12), .done(done12), .error(error12));

  ccff_bitstream_loader #(.CHAIN_LEN(1)) dut1 (
    .prog_clk(clk), .pReset(pReset), .start(start1), .s_data(s_data1), .s_valid(s_valid1),
    .s_ready(ready1), .ccff_head(head1), .ccff_shift_en(shift1), .ccff_tail(chain1),
    .busy(busy1), .done(done1), .error(error1));

  always #5 clk = ~clk;

  // External chains: plain shift registers clocked through the gate.
  assign tail12 = chain12[L-1];
  always @(posedge clk) begin
    if (shift12) chain12 <= {chain12[L-2:0], head12};
    if (shift1)  chain1  <= head1;
  end

  task automatic check1(input string tag, input int c, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic setc(input int c, input logic en, input logic hd, input logic rdy,
                      input logic bsy, input logic dn, input logic er);
    exp_en[c] = en; exp_head[c] = hd; exp_rdy[c] = rdy;
    exp_busy[c] = bsy; exp_done[c] = dn; exp_err[c] = er;
  endtask

  // Each byte costs (gap + 1) ready cycles then nb shift cycles; verify compares bit j with load bit j.
  task automatic build_model();
    int c, nb, bi;
    logic hold, err, bv;
    logic [7:0] b;
    logic [L-1:0] lbits;
    lbits = '0;
    setc(0, 1'b0, m_head, 1'b0, 1'b0, 1'b0, m_err);
    hold = m_head; err = 1'b0; c = 1;
    for (int p = 0; p < NPASS; p++) begin
      for (int i = 0; i < NBY; i++) begin
        b  = st_bytes[p*NBY + i];
        nb = (L - 8*i >= 8) ? 8 : L - 8*i;
        for (int g = 0; g <= st_gaps[p*NBY + i]; g++) begin
          setc(c, 1'b0, hold, 1'b1, 1'b1, 1'b0, err);
          c++;
        end
        for (int k = 0; k < nb; k++) begin
          bv = b[7-k];
          setc(c, 1'b1, bv, 1'b0, 1'b1, 1'b0, err);
          bi = 8*i + k;
          if (p == 0) lbits[L-1-bi] = bv;
          else if (bv != lbits[L-1-bi]) err = 1'b1;
          hold = bv;
          c++;
        end
      end
    end
    m_done = c;
    setc(c, 1'b0, hold, 1'b0, 1'b1, 1'b1, err);
    setc(c + 1, 1'b0, hold, 1'b0, 1'b0, 1'b0, err);
    m_bits = lbits; m_head_n = hold; m_err_n = err;
  endtask

  task automatic run12(input int abort_shift);
    int idx, gap_left, nshift, obs_done;
    logic [L-1:0] obs_bits;
    build_model();
    idx = 0; gap_left = st_gaps[0]; nshift = 0; obs_done = -1; obs_bits = '0;
    for (int c = 0; c <= m_done + 1; c++) begin
      @(negedge clk);
      check1("s_ready", c, ready12, exp_rdy[c]);
      check1("shift_en", c, shift12, exp_en[c]);
      check1("head", c, head12, exp_head[c]);
      check1("busy", c, busy12, exp_busy[c]);
      check1("done", c, done12, exp_done[c]);
      check1("error", c, error12, exp_err[c]);
      if (done12 === 1'b1 && obs_done < 0) obs_done = c;
      if (shift12 === 1'b1) begin
        if (nshift < L) obs_bits[L-1-nshift] = head12;
        nshift++;
        if (abort_shift > 0 && nshift == abort_shift) begin
          pReset = 1'b0;
          #1;
          check1("rst_ready", c, ready12, 1'b0);
          check1("rst_shift", c, shift12, 1'b0);
          check1("rst_head", c, head12, 1'b0);
          check1("rst_busy", c, busy12, 1'b0);
          check1("rst_done", c, done12, 1'b0);
          check1("rst_error", c, error12, 1'b0);
          start12 = 1'b0; s_valid12 = 1'b0;
          m_head = 1'b0; m_err = 1'b0;
          return;
        end
      end
      if (c == 0) start12 = 1'b1;
      else if (c <= m_done) start12 = ($urandom_range(0, 3) == 0);
      else start12 = 1'b0;
      if (ready12 === 1'b1) begin
        if (gap_left > 0) begin
          s_valid12 = 1'b0; s_data12 = 8'($urandom); gap_left--;
        end else begin
          s_valid12 = 1'b1; s_data12 = st_bytes[idx];
          if (idx < 3) idx++;
          gap_left = st_gaps[idx];
        end
      end else begin
        s_valid12 = 1'($urandom_range(0, 1)); s_data12 = 8'($urandom);
      end
    end
    s_valid12 = 1'b0; start12 = 1'b0;
    checki("load_bits", int'(obs_bits), int'(m_bits));
    checki("shift_count", nshift, NPASS * L);
    checki("done_cycle", obs_done, m_done);
    last_done = obs_done; last_bits = obs_bits; last_nshift = nshift;
    m_head = m_head_n; m_err = m_err_n;
  endtask

  initial begin
    int d1, nsh1;
    #2;
    check1("reset_ready", 0, ready12, 1'b0);
    check1("reset_head", 0, head12, 1'b0);
    check1("reset_shift", 0, shift12, 1'b0);
    check1("reset_busy", 0, busy12, 1'b0);
    check1("reset_done", 0, done12, 1'b0);
    check1("reset_error", 0, error12, 1'b0);
    check1("reset1_busy", 0, busy1, 1'b0);
    @(negedge clk); @(negedge clk);
    pReset = 1'b1;

    st_bytes[0] = 8'hA5; st_bytes[1] = 8'h3F; st_bytes[2] = 8'hA5; st_bytes[3] = 8'h3F;
    for (int i = 0; i < 4; i++) st_gaps[i] = 0;
    run12(0);
    checki("t1_bits", int'(last_bits), 32'hA53);
    checki("t1_done", last_done, NPASS * (L + NBY) + 1);

    st_gaps[1] = 3; st_gaps[3] = 3;
    run12(0);
    checki("t2_bits", int'(last_bits), 32'hA53);
    checki("t2_done", last_done, NPASS * (L + NBY + 3) + 1);

`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
    for (int i = 0; i < 4; i++) st_gaps[i] = 0;
    st_bytes[2] = 8'hA4;
    run12(0);
    @(negedge clk);
    check1("mismatch_sticky", 0, error12, 1'b1);
    st_bytes[2] = 8'hA5;
    run12(0);
`endif

    start12 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid12 = 1'b1; s_data12 = 8'($urandom);
      @(negedge clk);
      check1("idle_ready", i, ready12, 1'b0);
      check1("idle_shift", i, shift12, 1'b0);
      check1("idle_busy", i, busy12, 1'b0);
    end
    s_valid12 = 1'b0;

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NBY; i++) begin
        st_bytes[i] = 8'($urandom);
        st_bytes[NBY + i] = st_bytes[i];
      end
      for (int i = 0; i < 4; i++) st_gaps[i] = $urandom_range(0, 3);
      run12(0);
    end

    run12(5);
    @(negedge clk);
    pReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid12 = 1'b1; s_data12 = 8'($urandom);
      @(negedge clk);
      check1("post_rst_ready", i, ready12, 1'b0);
      check1("post_rst_shift", i, shift12, 1'b0);
      check1("post_rst_busy", i, busy12, 1'b0);
    end
    s_valid12 = 1'b0;
    st_bytes[0] = 8'hA5; st_bytes[1] = 8'h3F; st_bytes[2] = 8'hA5; st_bytes[3] = 8'h3F;
    for (int i = 0; i < 4; i++) st_gaps[i] = 0;
    run12(0);
    checki("post_rst_bits", int'(last_bits), 32'hA53);

    d1 = -1; nsh1 = 0;
    @(negedge clk);
    start1 = 1'b1; s_valid1 = 1'b1; s_data1 = 8'h80;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (shift1 === 1'b1) begin
        nsh1++;
        check1("len1_head", c, head1, 1'b1);
      end
      if (done1 === 1'b1 && d1 < 0) d1 = c;
    end
    s_valid1 = 1'b0;
    checki("len1_shifts", nsh1, NPASS);
    checki("len1_done", d1, 1 + 2 * NPASS);
    check1("len1_busy_end", 0, busy1, 1'b0);
    check1("len1_error", 0, error1, 1'b0);
    check1("len1_ready_end", 0, ready1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
